// File: rtl/button_conditioner_if.sv
// Button bus between the board-side push-buttons and the conditioned signals for the clock core.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (output btn_raw, input btn_level, btn_press, btn_release);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchroniser, debounce, press/release pulses and
// hold-to-auto-repeat, with fully independent identical logic per button.
module button_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0011,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave btn
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RPT  = 2'd2;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] rel_q;
    logic [DB_W-1:0]  db_cnt    [N_BTN];
    logic [RPT_W-1:0] rpt_cnt   [N_BTN];
    logic [1:0]       rpt_state [N_BTN];

    logic [N_BTN-1:0] db_done;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rpt_due;

    // rise/fall mark the edge on which the debounced level is about to flip
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            db_done[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
            rise[i]    = db_done[i] && !level[i];
            fall[i]    = db_done[i] && level[i];
            rpt_due[i] = ((rpt_state[i] == ST_WAIT) && (rpt_cnt[i] == DELAY_LAST)) ||
                         ((rpt_state[i] == ST_RPT)  && (rpt_cnt[i] == PERIOD_LAST));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn.btn_raw;
            sync2   <= sync1;
            // a release landing on a repeat terminal count suppresses that repeat
            press_q <= rise | (rpt_due & ~fall);
            rel_q   <= fall;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_done[i]) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                rpt_state[i] <= ST_IDLE;
                rpt_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!REPEAT_MASK[i] || fall[i]) begin
                    rpt_state[i] <= ST_IDLE;
                    rpt_cnt[i]   <= '0;
                end else begin
                    case (rpt_state[i])
                        ST_IDLE: begin
                            if (rise[i]) begin
                                rpt_state[i] <= ST_WAIT;
                                rpt_cnt[i]   <= '0;
                            end
                        end
                        ST_WAIT: begin
                            if (rpt_due[i]) begin
                                rpt_state[i] <= ST_RPT;
                                rpt_cnt[i]   <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                            end
                        end
                        ST_RPT: begin
                            if (rpt_due[i]) begin
                                rpt_cnt[i] <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                            end
                        end
                        default: begin
                            rpt_state[i] <= ST_IDLE;
                            rpt_cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = rel_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal timing expectations plus
// randomized button activity, all checked every cycle against a behavioural model.
module tb_button_conditioner;
    localparam int         N_BTN  = 4;
    localparam int         DB     = 4;
    localparam int         DELAY  = 10;
    localparam int         PERIOD = 3;
    localparam logic [3:0] MASK   = 4'b0011;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    button_conditioner_if #(.N_BTN(N_BTN)) bus ();

    button_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_MASK     (MASK),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N_BTN-1:0] sync_q [$];
    logic [N_BTN-1:0] s2_hist [$];
    logic [N_BTN-1:0] m_level;
    logic [N_BTN-1:0] m_press;
    logic [N_BTN-1:0] m_rel;
    int               cyc;
    int               rise_edge [N_BTN];

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        sync_q.delete();
        sync_q.push_back('0);
        sync_q.push_back('0);
        s2_hist.delete();
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
    endfunction

    // A level flips once the last DB synchronised samples all disagree with it; repeats
    // fall at fixed offsets from the accepted press while the level stays high.
    function automatic void model_step(logic [N_BTN-1:0] raw);
        logic [N_BTN-1:0] s2;
        bit               all_diff;
        int               d;
        s2 = sync_q.pop_front();
        sync_q.push_back(raw);
        s2_hist.push_back(s2);
        if (s2_hist.size() > DB) void'(s2_hist.pop_front());
        cyc++;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            all_diff = (s2_hist.size() == DB);
            for (int j = 0; j < s2_hist.size(); j++) begin
                if (s2_hist[j][i] == m_level[i]) all_diff = 0;
            end
            if (all_diff) begin
                if (!m_level[i]) begin
                    m_level[i]   = 1'b1;
                    m_press[i]   = 1'b1;
                    rise_edge[i] = cyc;
                end else begin
                    m_level[i] = 1'b0;
                    m_rel[i]   = 1'b1;
                end
            end else if (m_level[i] && MASK[i]) begin
                d = cyc - rise_edge[i];
                if (d >= DELAY && ((d - DELAY) % PERIOD) == 0) m_press[i] = 1'b1;
            end
        end
    endfunction

    initial begin
        logic [N_BTN-1:0] raw_s;
        logic             rst_s;
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk);
            raw_s = bus.btn_raw;
            rst_s = reset;
            #1;
            if (!rst_s) model_reset();
            else model_step(raw_s);
            check_output("model_level",   bus.btn_level,   m_level);
            check_output("model_press",   bus.btn_press,   m_press);
            check_output("model_release", bus.btn_release, m_rel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(int b, logic v);
        @(negedge clk);
        bus.btn_raw[b] = v;
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_clean_press();
        set_raw(0, 1'b1);
        repeat (5) tick();
        check_output("t1_level_before", bus.btn_level[0], 1'b0);
        tick();
        check_output("t1_level", bus.btn_level[0], 1'b1);
        check_output("t1_press", bus.btn_press[0], 1'b1);
        tick();
        check_output("t1_press_once", bus.btn_press[0], 1'b0);
        set_raw(0, 1'b0);
        settle(12);
    endtask

    task automatic test_bounce();
        logic bounce [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int   n_press = 0;
        int   at = -1;
        for (int k = 0; k < 8; k++) begin
            set_raw(2, bounce[k]);
            tick();
            if (bus.btn_press[2]) n_press++;
        end
        set_raw(2, 1'b1);
        for (int e = 0; e < 25; e++) begin
            tick();
            if (bus.btn_press[2]) begin
                n_press++;
                at = e;
            end
        end
        check_output("t2_press_count", n_press, 1);
        check_output("t2_press_edge", at, 5);
        set_raw(2, 1'b0);
        settle(12);
    endtask

    task automatic test_repeat();
        int          want_edges [8] = '{5, 15, 18, 21, 24, 27, 30, 33};
        logic [63:0] seen = '0;
        logic [63:0] want = '0;
        int          rel_at = -1;
        int          n_rel = 0;
        foreach (want_edges[k]) want[want_edges[k]] = 1'b1;
        set_raw(1, 1'b1);
        for (int e = 0; e < 36; e++) begin
            tick();
            if (bus.btn_press[1]) seen[e] = 1'b1;
        end
        check_output("t3_press_edges_lo", seen[31:0], want[31:0]);
        check_output("t3_press_edges_hi", seen[63:32], want[63:32]);
        set_raw(1, 1'b0);
        for (int e = 0; e < 20; e++) begin
            tick();
            if (bus.btn_release[1]) begin
                n_rel++;
                if (rel_at < 0) rel_at = e;
            end
        end
        check_output("t3_release_edge", rel_at, 5);
        check_output("t3_release_count", n_rel, 1);
        settle(4);
    endtask

    task automatic test_release_at_terminal();
        set_raw(0, 1'b1);
        repeat (16) tick();
        set_raw(0, 1'b0);
        repeat (5) tick();
        tick();
        check_output("t4_no_press", bus.btn_press[0], 1'b0);
        check_output("t4_release", bus.btn_release[0], 1'b1);
        check_output("t4_level", bus.btn_level[0], 1'b0);
        settle(12);
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.btn_raw[3] = 1'b1;
        bus.btn_raw[0] = 1'b1;
        repeat (5) tick();
        tick();
        check_output("t5_press_both", bus.btn_press, 4'b1001);
        set_raw(3, 1'b0);
        repeat (3) tick();
        set_raw(0, 1'b0);
        repeat (2) tick();
        tick();
        check_output("t5_release_mode", bus.btn_release, 4'b1000);
        repeat (2) tick();
        tick();
        check_output("t5_release_op2", bus.btn_release, 4'b0001);
        settle(8);
    endtask

    task automatic test_reset_mid_hold();
        set_raw(1, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("t6_reset_level", bus.btn_level, 4'b0000);
        check_output("t6_reset_press", bus.btn_press, 4'b0000);
        check_output("t6_reset_release", bus.btn_release, 4'b0000);
        settle(2);
        reset = 1'b1;
        repeat (5) tick();
        tick();
        check_output("t6_new_press", bus.btn_press[1], 1'b1);
        repeat (9) tick();
        check_output("t6_no_early_repeat", bus.btn_press[1], 1'b0);
        tick();
        check_output("t6_first_repeat", bus.btn_press[1], 1'b1);
        set_raw(1, 1'b0);
        settle(12);
    endtask

    // Random per-button hold lengths mix sub-debounce glitches with long repeat holds.
    task automatic apply_stimulus(int n_cycles);
        int hold [N_BTN] = '{0, 0, 0, 0};
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
            else reset = 1'b1;
            for (int i = 0; i < N_BTN; i++) begin
                if (hold[i] == 0) begin
                    bus.btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(12, 40) : $urandom_range(1, 6);
                end else begin
                    hold[i]--;
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
        bus.btn_raw = '0;
        settle(12);
    endtask

    initial begin
        bus.btn_raw = '0;
        reset = 1'b0;
        settle(3);
        check_output("reset_state", {bus.btn_level, bus.btn_press, bus.btn_release}, 12'h000);
        reset = 1'b1;
        settle(4);
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_at_terminal();
        test_simultaneous();
        test_reset_mid_hold();
        apply_stimulus(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
